push_pwm: RTL and testbench
===========================

Name: push_pwm

Overview:
Single-channel, fixed-period PWM generator used to drive push-rod and servo actuators in the arm subsystem. Both the period and the duty are measured in clk cycles. The duty is a 20-bit count that is sampled once per period, so a duty change never produces a glitch or a runt pulse. The block feeds an output pin directly and has no handshake.

Parameters:
PERIOD_CNT, 1_000_000, PWM period in clk cycles (default gives 20 ms at 50 MHz). Legal range is 2..2^20.
CNT_W, 20, counter and duty width in bits. Must satisfy 2^CNT_W >= PERIOD_CNT.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous, active-low reset
duty  input  20  requested high time in clk cycles; unsigned; may change at any time
pwm_wave  output  1  PWM output; registered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cnt=0, duty_q=0, pwm_wave=0.
  - Release is synchronous to clk. The first period after reset is fully low, because duty_q=0.
- Period counter (cnt, CNT_W bits):
  - Counts 0..PERIOD_CNT-1, incrementing by 1 each clk.
  - At PERIOD_CNT-1 it wraps to 0 on the next edge.
- Duty shadow register (duty_q):
  - Loads from duty on the same edge where cnt wraps from PERIOD_CNT-1 to 0. It holds at all other times.
  - Changes to duty mid-period are ignored until the next period boundary. Only the value present in the last cycle of a period matters.
- Output: on each edge, pwm_wave <= (cnt < duty_q), using an unsigned compare.
  - pwm_wave therefore lags cnt by one clk.
  - Within each period it is high for exactly min(duty_q, PERIOD_CNT) consecutive cycles, then low for the remainder.
- Boundary conditions:
  - duty_q=0: output constantly low, with no single-cycle pulse.
  - duty_q >= PERIOD_CNT: output constantly high across the period boundary (100 %), with no low cycle at the wrap.
  - duty_q = PERIOD_CNT-1: exactly one low cycle per period.
  - Values of duty above PERIOD_CNT saturate; they must not wrap or alias.
  - Reset asserted mid-period: output drops to 0 immediately (asynchronously) and the counter restarts from 0.
- No combinational path from duty to pwm_wave.

Decomposition:
- No shared package is needed.
- An optional local constant, CNT_MAX = PERIOD_CNT-1, may be defined inside the module.
- One natural sub-module: pwm_period_counter. It is a free-running modulo-N counter that produces cnt and a wrap strobe.
- The compare stage and the shadow register stay in push_pwm.

Test Plan (PERIOD_CNT=50, clk 10 ns):
1. Hold rst_n=0 with duty=10, then release -> pwm_wave=0 during reset and for the whole first period (50 cycles). From the second period on, it is high for 10 cycles and low for 40, repeating every 500 ns.
2. Steady duty=10, then change to 5 at cycle 20 of a period -> the current period keeps its 10-cycle high time. The next period has a 5-cycle high time, with no runt pulse.
3. duty sequence 3, 20, 15, each held for at least 2 periods -> measured high times are 3, 20, 15 cycles. Each change takes effect at the first period start after the change.
4. duty=0 -> pwm_wave stays 0 for at least 3 periods. duty=50 and duty=1_000 -> pwm_wave stays 1 continuously, including across wraps.
5. duty=49 -> exactly 1 low cycle per period. duty=1 -> exactly 1 high cycle per period.
6. Assert rst_n low mid-high-phase -> pwm_wave goes to 0 without waiting for a clk edge. After release, the first period is all low, because duty_q was reset to 0.

Source files
------------

// File: rtl/push_pwm_pkg.sv
// Shared defaults for the push-rod / servo PWM generator.
package push_pwm_pkg;

  // 20 ms period at 50 MHz; a 20-bit count covers it.
  localparam int DEFAULT_PERIOD_CNT = 1_000_000;
  localparam int DEFAULT_CNT_W      = 20;

endpackage : push_pwm_pkg

// File: rtl/push_pwm_if.sv
// Duty request and PWM output bundle between the arm controller and push_pwm.
interface push_pwm_if
  import push_pwm_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  // No handshake: duty is a level the PWM samples once per period, and
  // pwm_wave is a continuous registered level that drives the pin.
  logic [CNT_W-1:0] duty;
  logic             pwm_wave;

  modport master (
    output duty,
    input  pwm_wave
  );

  modport slave (
    input  duty,
    output pwm_wave
  );

endinterface : push_pwm_if

// File: rtl/pwm_period_counter.sv
// Free-running modulo-PERIOD_CNT counter with a strobe in the last cycle of each period.
module pwm_period_counter
  import push_pwm_pkg::*;
#(
  parameter int PERIOD_CNT = DEFAULT_PERIOD_CNT,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD_CNT - 1);

  // wrap is high while cnt sits at its last value, i.e. on the edge that returns it to 0.
  assign wrap = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : pwm_period_counter

// File: rtl/push_pwm.sv
// Fixed-period PWM: duty is shadowed at each period boundary and compared against the period count.
module push_pwm
  import push_pwm_pkg::*;
#(
  parameter int PERIOD_CNT = DEFAULT_PERIOD_CNT,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  push_pwm_if.slave  pwm
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] duty_q;
  logic             pwm_q;

  pwm_period_counter #(
    .PERIOD_CNT (PERIOD_CNT),
    .CNT_W      (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Only the duty present in the last cycle of a period is used, so mid-period
  // changes cannot create a runt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (wrap) begin
      duty_q <= pwm.duty;
    end
  end

  // cnt never exceeds PERIOD_CNT-1, so any duty_q >= PERIOD_CNT gives a solid
  // high level across the wrap without extra saturation logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= (cnt < duty_q);
    end
  end

  assign pwm.pwm_wave = pwm_q;

endmodule : push_pwm

// File: tb/tb_push_pwm.sv
// Directed bench for push_pwm with PERIOD_CNT=50: per-cycle expected levels go through a scoreboard queue.
`timescale 1ns/1ps
module tb_push_pwm;

  localparam int PERIOD = 50;
  localparam int W      = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  push_pwm_if #(.CNT_W(W)) pif ();

  push_pwm #(
    .PERIOD_CNT (PERIOD),
    .CNT_W      (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm   (pif.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  string      name_q[$];
  int         n_vec  = 0;
  int         n_err  = 0;
  bit         mon_en = 1'b0;

  // ---------------- monitor: one sample per clk, #1 after the edge ----------------
  initial begin : monitor
    logic [0:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL underflow: pwm_wave=%0b sampled with no expected entry at %0t", pif.pwm_wave, $time);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (pif.pwm_wave !== e[0]) begin
            n_err++;
            $display("FAIL %s: pwm_wave=%0b expected %0b at %0t", nm, pif.pwm_wave, e[0], $time);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge that precedes the first rising edge of a period.
  // Duty starts at a, switches to b before cycle chg (chg<0: never); exp_high is
  // the hand-computed high time of this period (from the duty at the end of the previous one).
  task automatic run_period(input string name, input logic [W-1:0] a, input int chg,
                            input logic [W-1:0] b, input int exp_high);
    pif.duty = a;
    for (int c = 0; c < PERIOD; c++) begin
      exp_q.push_back(1'(c < exp_high));
      name_q.push_back($sformatf("%s[%0d]", name, c));
    end
    for (int c = 0; c < PERIOD; c++) begin
      if (c == chg) pif.duty = b;
      @(negedge clk);
    end
  endtask

  task automatic check_now(input string name, input logic exp);
    n_vec++;
    if (pif.pwm_wave !== exp) begin
      n_err++;
      $display("FAIL %s: pwm_wave=%0b expected %0b at %0t", name, pif.pwm_wave, exp, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    pif.duty = 20'd10;
    rst_n    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_now("t1_in_reset", 1'b0);
    end

    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1: first period after reset is all low
    run_period("t1_p0", 20'd10, -1, 20'd10, 0);
    run_period("t1_p1", 20'd10, -1, 20'd10, 10);
    // 2: mid-period change is deferred
    run_period("t2_keep", 20'd10, 20, 20'd5, 10);
    run_period("t2_new",  20'd5,  -1, 20'd5, 5);
    // 3: duty sequence, plus a change landing in the very last cycle
    run_period("t3_a", 20'd3,  -1, 20'd3,  5);
    run_period("t3_b", 20'd3,  -1, 20'd3,  3);
    run_period("t3_c", 20'd20, -1, 20'd20, 3);
    run_period("t3_d", 20'd20, -1, 20'd20, 20);
    run_period("t3_e", 20'd15, -1, 20'd15, 20);
    run_period("t3_f", 20'd15, -1, 20'd15, 15);
    run_period("t3_late",     20'd15, 49, 20'd30, 15);
    run_period("t3_late_eff", 20'd30, -1, 20'd30, 30);
    // 4: 0 % and saturated 100 %
    run_period("t4_zero0", 20'd0,    -1, 20'd0,     30);
    run_period("t4_zero1", 20'd0,    -1, 20'd0,     0);
    run_period("t4_zero2", 20'd0,    -1, 20'd0,     0);
    run_period("t4_zero3", 20'd50,   -1, 20'd50,    0);
    run_period("t4_full50",  20'd1000, -1, 20'd1000,  50);
    run_period("t4_full1k",  20'd1000, -1, 20'hFFFFF, 50);
    run_period("t4_fullmax", 20'd49,   -1, 20'd49,    50);
    // 5: one low cycle, then one high cycle
    run_period("t5_49a", 20'd49, -1, 20'd49, 49);
    run_period("t5_1a",  20'd1,  -1, 20'd1,  49);
    run_period("t5_1b",  20'd1,  -1, 20'd1,  1);
    run_period("t5_1c",  20'd10, -1, 20'd10, 1);

    // 6: async reset in the high phase of a duty=10 period
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(1'b1);
      name_q.push_back($sformatf("t6_pre[%0d]", c));
    end
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check_now("t6_high_before_reset", 1'b1);
    rst_n = 1'b0;
    #1;
    check_now("t6_async_drop", 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_now("t6_in_reset", 1'b0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run_period("t6_after_p0", 20'd10, -1, 20'd10, 0);
    run_period("t6_after_p1", 20'd10, -1, 20'd10, 10);
    mon_en = 1'b0;

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_push_pwm
